// File: rtl/ula_pkg.sv
// Shared ULA definitions: operand width and divider FSM states.
// Imported by the divider datapath and its subtractor.
package ula_pkg;

    localparam int WIDTH = 4;
    localparam int ITER  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/subtrator_4bits.sv
// 4-bit ripple borrow subtractor: dif = A - B - Bin.
// Bout is the borrow out of the MSB stage.
module subtrator_4bits
    import ula_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] dif,
    output logic             Bout
);

    logic borrow;

    // Full-subtractor chain, LSB first
    always_comb begin
        borrow = Bin;
        dif    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dif[i] = A[i] ^ B[i] ^ borrow;
            borrow = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow);
        end
        Bout = borrow;
    end

endmodule

// File: rtl/divisor_sequencial_4bits.sv
// Restoring 4-bit unsigned divider, one trial subtraction per clock.
// start/done handshake; all outputs registered.
module divisor_sequencial_4bits
    import ula_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int IT = ITER
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quociente,
    output logic [W-1:0] resto,
    output logic         erro_div0
);

    localparam int CW = $clog2(IT);
    localparam logic [CW-1:0] LAST = CW'(IT - 1);

    div_state_t   state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dq_q, dq_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] res_q, res_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [W-1:0] shifted;
    logic [W-1:0] dif;
    logic         bout;
    logic         take;

    assign shifted = {rem_q[W-2:0], dq_q[W-1]};

    subtrator_4bits u_sub (
        .A    (shifted),
        .B    (div_q),
        .Bin  (1'b0),
        .dif  (dif),
        .Bout (bout)
    );

    // A set MSB means the shifted value exceeds 4 bits, so it always fits;
    // mod-16 wrap of dif still yields the correct remainder.
    assign take = rem_q[W-1] | ~bout;

    // Next-state and next-output logic for the divider FSM
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        div_d   = div_q;
        quo_d   = quo_q;
        res_d   = res_q;
        err_d   = err_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d    = A;
                    div_d   = B;
                    rem_d   = '0;
                    count_d = '0;
                    err_d   = (B == '0);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_d  = 1'b1;
                rem_d   = take ? dif : shifted;
                dq_d    = {dq_q[W-2:0], take};
                count_d = count_q + 1'b1;
                if (count_q == LAST) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                quo_d   = dq_q;
                res_d   = rem_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quociente = quo_q;
    assign resto     = res_q;
    assign erro_div0 = err_q;

endmodule
